// File: rtl/alu_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// alu_arbiter_pkg
//   Shared definitions for the Hack ALU arbiter slice: Hack word width,
//   ALU control-word width and the common control codes, plus the
//   sequencer state type.
// ---------------------------------------------------------------------------
package alu_arbiter_pkg;

    localparam int HACK_W = 16;
    localparam int CTL_W  = 6;

    // Control word layout: {zx, nx, zy, ny, f, no}
    localparam logic [CTL_W-1:0] CTL_ZERO    = 6'b101010;
    localparam logic [CTL_W-1:0] CTL_ONE     = 6'b111111;
    localparam logic [CTL_W-1:0] CTL_NEG1    = 6'b111010;
    localparam logic [CTL_W-1:0] CTL_XPLUSY  = 6'b000010;
    localparam logic [CTL_W-1:0] CTL_XMINUSY = 6'b010011;
    localparam logic [CTL_W-1:0] CTL_XANDY   = 6'b000000;
    localparam logic [CTL_W-1:0] CTL_XORY    = 6'b010101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles the requester-side bus and the shared-ALU bus of alu_arbiter.
//   slave  : arbiter view (consumes requests and ALU results, drives
//            acks, responses and the ALU operands)
//   master : environment view (requesters plus the external hack_alu)
// Signals
//   req / req_x / req_y / req_ctl : per-requester request and operands
//   ack                           : one-hot, single-cycle completion
//   rsp_out / rsp_zr / rsp_ng     : registered ALU result and flags
//   grant_id / busy               : current/last winner, sequencer active
//   alu_x / alu_y / alu_ctl       : registered operands to hack_alu
//   alu_out / alu_zr / alu_ng     : combinational result from hack_alu
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
);
    import alu_arbiter_pkg::*;

    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ*CTL_W-1:0] req_ctl;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH-1:0]       rsp_out;
    logic                   rsp_zr;
    logic                   rsp_ng;
    logic [IDW-1:0]         grant_id;
    logic                   busy;
    logic [WIDTH-1:0]       alu_x;
    logic [WIDTH-1:0]       alu_y;
    logic [CTL_W-1:0]       alu_ctl;
    logic [WIDTH-1:0]       alu_out;
    logic                   alu_zr;
    logic                   alu_ng;

    modport slave (
        input  req, req_x, req_y, req_ctl, alu_out, alu_zr, alu_ng,
        output ack, rsp_out, rsp_zr, rsp_ng, grant_id, busy,
               alu_x, alu_y, alu_ctl
    );

    modport master (
        output req, req_x, req_y, req_ctl, alu_out, alu_zr, alu_ng,
        input  ack, rsp_out, rsp_zr, rsp_ng, grant_id, busy,
               alu_x, alu_y, alu_ctl
    );

endinterface

// File: rtl/alu_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting at index ptr and
//   wrapping modulo N_REQ; returns the first set index. Generic enough to
//   arbitrate memory ports as well as the ALU.
// Ports
//   req   in  N_REQ  request vector
//   ptr   in  IDW    highest-priority index for this scan
//   valid out 1      at least one request present
//   g     out IDW    winning index (0 when valid=0)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   g
);

    // One extra bit so ptr + k never overflows before the modulo fold.
    logic [IDW:0] idx;

    always_comb begin
        valid = 1'b0;
        g     = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, ptr} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(N_REQ)) begin
                idx = idx - (IDW+1)'(N_REQ);
            end
            if (!valid && req[idx[IDW-1:0]]) begin
                valid = 1'b1;
                g     = idx[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational Hack ALU among N_REQ requesters.
//   IDLE picks a winner round-robin and latches its operands, ISSUE lets the
//   ALU settle and captures the result, DONE holds the one-cycle ack.
//   Fixed latency: ack is visible the cycle after the grant edge, and a new
//   grant can happen at most every third edge.
// Ports
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset
//   bus   slave modport of alu_arbiter_if (requests, responses, ALU link)
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   ptr_after_g;
    logic             pick_valid;
    logic [IDW-1:0]   pick_g;
    logic             grant_en;
    logic             capture_en;

    logic [WIDTH-1:0] x_arr   [N_REQ];
    logic [WIDTH-1:0] y_arr   [N_REQ];
    logic [CTL_W-1:0] ctl_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign x_arr[i]   = bus.req_x[i*WIDTH +: WIDTH];
        assign y_arr[i]   = bus.req_y[i*WIDTH +: WIDTH];
        assign ctl_arr[i] = bus.req_ctl[i*CTL_W +: CTL_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .g     (pick_g)
    );

    // Priority moves to the requester just after the winner.
    always_comb begin
        ptr_after_g = pick_g + IDW'(1);
        if (pick_g == IDW'(N_REQ-1)) begin
            ptr_after_g = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        capture_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_en   = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                capture_en = 1'b1;
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Operands are sampled only on the grant edge; later changes on the
    // request bus are invisible to the operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr          <= '0;
            bus.ack      <= '0;
            bus.rsp_out  <= '0;
            bus.rsp_zr   <= 1'b0;
            bus.rsp_ng   <= 1'b0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
            bus.alu_x    <= '0;
            bus.alu_y    <= '0;
            bus.alu_ctl  <= '0;
        end else begin
            bus.ack  <= '0;
            bus.busy <= (state_next != ST_IDLE);
            if (grant_en) begin
                bus.alu_x    <= x_arr[pick_g];
                bus.alu_y    <= y_arr[pick_g];
                bus.alu_ctl  <= ctl_arr[pick_g];
                bus.grant_id <= pick_g;
                ptr          <= ptr_after_g;
            end
            if (capture_en) begin
                bus.rsp_out <= bus.alu_out;
                bus.rsp_zr  <= bus.alu_zr;
                bus.rsp_ng  <= bus.alu_ng;
                bus.ack     <= N_REQ'(1) << bus.grant_id;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Drives alu_arbiter with a Hack ALU built from the gate-level rules,
//   and checks every cycle against a transaction-level reference: a grant
//   at edge G makes ack visible after edge G+1, the next grant is possible
//   at edge G+3, and the result is the arithmetic meaning of the control
//   code applied to the operands present at the grant edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_arbiter_if #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) bus ();

    alu_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Requester side stimulus
    logic [N-1:0]     req_v;
    logic [W-1:0]     x_v   [N];
    logic [W-1:0]     y_v   [N];
    logic [CTL_W-1:0] ctl_v [N];

    assign bus.req = req_v;

    always_comb begin
        bus.req_x   = '0;
        bus.req_y   = '0;
        bus.req_ctl = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*W +: W]           = x_v[i];
            bus.req_y[i*W +: W]           = y_v[i];
            bus.req_ctl[i*CTL_W +: CTL_W] = ctl_v[i];
        end
    end

    // External Hack ALU
    logic [W-1:0] ax, ay, ao;
    always_comb begin
        ax = bus.alu_ctl[5] ? '0 : bus.alu_x;
        ax = bus.alu_ctl[4] ? ~ax : ax;
        ay = bus.alu_ctl[3] ? '0 : bus.alu_y;
        ay = bus.alu_ctl[2] ? ~ay : ay;
        ao = bus.alu_ctl[1] ? (ax + ay) : (ax & ay);
        ao = bus.alu_ctl[0] ? ~ao : ao;
        bus.alu_out = ao;
        bus.alu_zr  = (ao == '0);
        bus.alu_ng  = ao[W-1];
    end

    // Bookkeeping
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference model state
    int           m_ptr;
    int           exp_ack_cyc;
    int           grant_cyc;
    int           free_cyc;
    int           exp_g;
    logic [W-1:0] exp_res;
    int           m_grant;
    logic [W-1:0] m_alu_x, m_alu_y;
    logic [5:0]   m_alu_ctl;
    logic [W-1:0] m_rsp;
    logic         m_zr, m_ng;

    logic         auto_raise;
    logic [N-1:0] pend;
    int           acks_q[$];
    int           ack_cyc_q[$];
    logic [5:0]   codes [7];
    int           exp_order [6];

    function automatic logic [W-1:0] op_ref(input logic [5:0] c,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] y);
        case (c)
            CTL_ZERO:    return '0;
            CTL_ONE:     return 16'd1;
            CTL_NEG1:    return 16'hFFFF;
            CTL_XPLUSY:  return x + y;
            CTL_XMINUSY: return x - y;
            CTL_XANDY:   return x & y;
            CTL_XORY:    return x | y;
            default:     return 'x;
        endcase
    endfunction

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr       = 0;
        exp_ack_cyc = -1;
        grant_cyc   = -10;
        free_cyc    = 0;
        exp_g       = 0;
        exp_res     = '0;
        m_grant     = 0;
        m_alu_x     = '0;
        m_alu_y     = '0;
        m_alu_ctl   = '0;
        m_rsp       = '0;
        m_zr        = 1'b0;
        m_ng        = 1'b0;
        pend        = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ack"},  32'(bus.ack), 0);
        chk({tag, "_out"},  32'(bus.rsp_out), 0);
        chk({tag, "_zr"},   32'(bus.rsp_zr), 0);
        chk({tag, "_ng"},   32'(bus.rsp_ng), 0);
        chk({tag, "_gid"},  32'(bus.grant_id), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_ax"},   32'(bus.alu_x), 0);
        chk({tag, "_ay"},   32'(bus.alu_y), 0);
        chk({tag, "_actl"}, 32'(bus.alu_ctl), 0);
    endtask

    // One clock: predict this edge, advance, compare, apply requester rule.
    task automatic step();
        logic [N-1:0] ack_seen;
        int g;
        if (rst_n && cyc >= free_cyc && req_v != '0) begin
            g           = rr_winner(req_v, m_ptr);
            exp_g       = g;
            exp_res     = op_ref(ctl_v[g], x_v[g], y_v[g]);
            m_alu_x     = x_v[g];
            m_alu_y     = y_v[g];
            m_alu_ctl   = ctl_v[g];
            m_grant     = g;
            m_ptr       = (g + 1) % N;
            grant_cyc   = cyc;
            exp_ack_cyc = cyc + 1;
            free_cyc    = cyc + 3;
        end
        @(posedge clk);
        #1;
        if (cyc == exp_ack_cyc) begin
            m_rsp = exp_res;
            m_zr  = (exp_res == '0);
            m_ng  = exp_res[W-1];
        end
        chk("ack",  32'(bus.ack), (cyc == exp_ack_cyc) ? 32'(1 << exp_g) : 32'd0);
        chk("busy", 32'(bus.busy), 32'(cyc >= grant_cyc && cyc <= grant_cyc + 1));
        chk("gid",  32'(bus.grant_id), 32'(m_grant));
        chk("rsp_out", 32'(bus.rsp_out), 32'(m_rsp));
        chk("rsp_zr",  32'(bus.rsp_zr), 32'(m_zr));
        chk("rsp_ng",  32'(bus.rsp_ng), 32'(m_ng));
        chk("alu_x",   32'(bus.alu_x), 32'(m_alu_x));
        chk("alu_y",   32'(bus.alu_y), 32'(m_alu_y));
        chk("alu_ctl", 32'(bus.alu_ctl), 32'(m_alu_ctl));
        ack_seen = bus.ack;
        for (int i = 0; i < N; i++) begin
            if (ack_seen[i]) begin
                acks_q.push_back(i);
                ack_cyc_q.push_back(cyc);
            end
        end
        if (auto_raise) req_v = req_v | pend;
        pend  = ack_seen;
        req_v = req_v & ~ack_seen;
        cyc++;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_v      = '0;
        auto_raise = 1'b0;
        for (int i = 0; i < N; i++) begin
            x_v[i]   = '0;
            y_v[i]   = '0;
            ctl_v[i] = '0;
        end
        codes     = '{CTL_ZERO, CTL_ONE, CTL_NEG1, CTL_XPLUSY, CTL_XMINUSY, CTL_XANDY, CTL_XORY};
        exp_order = '{0, 1, 2, 3, 0, 1};
        model_reset();

        // Reset state, then idle with no requests
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (10) step();
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_ack", 32'(bus.ack), 0);

        // Single add from requester 0
        x_v[0] = 16'd5; y_v[0] = 16'd3; ctl_v[0] = CTL_XPLUSY;
        req_v  = 4'b0001;
        step();
        step();
        chk("add_ack", 32'(bus.ack), 32'h1);
        chk("add_out", 32'(bus.rsp_out), 32'd8);
        chk("add_zr",  32'(bus.rsp_zr), 0);
        chk("add_ng",  32'(bus.rsp_ng), 0);
        step();

        // Flags: negative result, then zero result
        x_v[1] = 16'd3; y_v[1] = 16'd5; ctl_v[1] = CTL_XMINUSY;
        req_v  = 4'b0010;
        step();
        step();
        chk("sub_ack", 32'(bus.ack), 32'h2);
        chk("sub_out", 32'(bus.rsp_out), 32'hFFFE);
        chk("sub_ng",  32'(bus.rsp_ng), 1);
        chk("sub_zr",  32'(bus.rsp_zr), 0);
        step();
        ctl_v[1] = CTL_ZERO;
        req_v    = 4'b0010;
        step();
        step();
        chk("zero_out", 32'(bus.rsp_out), 0);
        chk("zero_zr",  32'(bus.rsp_zr), 1);
        chk("zero_ng",  32'(bus.rsp_ng), 0);
        step();

        // Grant at the last index wraps priority back to 0
        x_v[3] = 16'h00F0; y_v[3] = 16'h0F00; ctl_v[3] = CTL_XORY;
        req_v  = 4'b1000;
        repeat (3) step();
        chk("wrap3_out", 32'(bus.rsp_out), 32'h0FF0);

        // Round-robin with all requesters re-raising after each ack
        for (int i = 0; i < N; i++) begin
            x_v[i] = 16'(i * 10); y_v[i] = 16'(i + 1); ctl_v[i] = CTL_XPLUSY;
        end
        acks_q.delete();
        ack_cyc_q.delete();
        auto_raise = 1'b1;
        req_v      = 4'b1111;
        repeat (17) step();
        auto_raise = 1'b0;
        pend       = '0;
        req_v      = '0;
        step();
        chk("rr_count", 32'(acks_q.size()), 6);
        for (int k = 0; k < 6 && k < acks_q.size(); k++) begin
            chk("rr_order", 32'(acks_q[k]), 32'(exp_order[k]));
        end
        for (int k = 1; k < 6 && k < ack_cyc_q.size(); k++) begin
            chk("rr_spacing", 32'(ack_cyc_q[k] - ack_cyc_q[k-1]), 3);
        end

        // Priority at 3 with requests on 0 and 2; operands change mid-op
        req_v = 4'b0100;
        repeat (3) step();
        x_v[0] = 16'd100; y_v[0] = 16'd30; ctl_v[0] = CTL_XMINUSY;
        x_v[2] = 16'd7;   y_v[2] = 16'd9;  ctl_v[2] = CTL_XPLUSY;
        req_v  = 4'b0101;
        step();
        chk("skip_gid0", 32'(bus.grant_id), 0);
        x_v[0] = 16'd1; y_v[0] = 16'd1; ctl_v[0] = CTL_XANDY;
        step();
        chk("latched_ack", 32'(bus.ack), 32'h1);
        chk("latched_out", 32'(bus.rsp_out), 32'd70);
        step();
        step();
        chk("skip_gid2", 32'(bus.grant_id), 2);
        step();
        chk("skip_out2", 32'(bus.rsp_out), 32'd16);
        step();

        // Asynchronous reset while an operation is in ISSUE
        x_v[1] = 16'h1234; y_v[1] = 16'h0F0F; ctl_v[1] = CTL_XANDY;
        req_v  = 4'b0010;
        step();
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        model_reset();
        req_v  = 4'b0110;
        x_v[2] = 16'h8000; y_v[2] = 16'h0001; ctl_v[2] = CTL_XORY;
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        chk("rst_restart_gid", 32'(bus.grant_id), 1);
        step();
        chk("rst_after_out", 32'(bus.rsp_out), 32'h0204);
        step();
        step();
        chk("rst_next_gid", 32'(bus.grant_id), 2);
        step();
        chk("rst_next_ng", 32'(bus.rsp_ng), 1);
        step();

        // Randomized traffic; operands churn every cycle
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) begin
                x_v[i]   = 16'($urandom);
                y_v[i]   = ($urandom_range(0, 7) == 0) ? x_v[i] : 16'($urandom);
                ctl_v[i] = codes[$urandom_range(0, 6)];
                if (!req_v[i] && $urandom_range(0, 3) == 0) req_v[i] = 1'b1;
            end
            step();
        end
        repeat (15) step();
        chk("drain_req", 32'(req_v), 0);
        chk("drain_busy", 32'(bus.busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
